// File: rtl/pixel_timing_if.sv
// rtl/pixel_timing_if.sv - pixel PLL lock input and video timing outputs bundle
interface pixel_timing_if;
    logic        pll_locked;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        frame_start;
    logic        line_start;
    logic        timing_valid;
    logic [23:0] rgb;

    modport master (
        input  pll_locked,
        output hsync, vsync, de, pix_x, pix_y,
        output frame_start, line_start, timing_valid, rgb
    );

    modport slave (
        output pll_locked,
        input  hsync, vsync, de, pix_x, pix_y,
        input  frame_start, line_start, timing_valid, rgb
    );
endinterface

// File: rtl/pixel_timing_gen.sv
// rtl/pixel_timing_gen.sv - lock-qualified video timing generator; colour bars when PIXEL_TEST_PATTERN_EN is defined
module pixel_timing_gen #(
    parameter int H_ACTIVE  = 1920,
    parameter int H_FP      = 88,
    parameter int H_SYNC    = 44,
    parameter int H_BP      = 148,
    parameter int V_ACTIVE  = 1080,
    parameter int V_FP      = 4,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 36,
    parameter int LOCK_WAIT = 1024
) (
    input  logic           clk,
    input  logic           rst,
    pixel_timing_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS  = 12'(H_ACTIVE);
    localparam logic [11:0] V_VIS  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_ON  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_OFF = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_ON  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_OFF = 12'(V_ACTIVE + V_FP + V_SYNC);

    localparam int              LW_W      = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [LW_W-1:0] LOCK_LAST = LW_W'(LOCK_WAIT - 1);

    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

    state_t          state, next_state;
    logic            lk_m, lk_s;
    logic [LW_W-1:0] lock_cnt;
    logic            lock_clr, lock_inc;
    logic            run_adv;
    logic [11:0]     h_cnt, v_cnt;
    logic            vis, hs_d, vs_d;

    logic        hsync_q, vsync_q, de_q, fs_q, ls_q, tv_q;
    logic [11:0] x_q, y_q;

    // Two-flop synchroniser: pll_locked is asynchronous to the pixel clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_m <= 1'b0;
            lk_s <= 1'b0;
        end else begin
            lk_m <= vid.pll_locked;
            lk_s <= lk_m;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_LOCK;
        else     state <= next_state;
    end

    // Lock qualification: lk_s must stay high LOCK_WAIT cycles in SETTLE before RUN
    always_comb begin
        next_state = state;
        lock_clr   = 1'b0;
        lock_inc   = 1'b0;
        case (state)
            WAIT_LOCK: begin
                if (lk_s) begin
                    next_state = SETTLE;
                    lock_clr   = 1'b1;
                end
            end
            SETTLE: begin
                if (!lk_s)                     next_state = WAIT_LOCK;
                else if (lock_cnt == LOCK_LAST) next_state = RUN;
                else                           lock_inc   = 1'b1;
            end
            RUN: begin
                if (!lk_s) next_state = WAIT_LOCK;
            end
            default: next_state = WAIT_LOCK;
        endcase
    end

    // Raster advances only in RUN with lock still present; losing lock blanks on the same edge
    assign run_adv = (state == RUN) && lk_s;

    // Lock qualification counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           lock_cnt <= '0;
        else if (lock_clr) lock_cnt <= '0;
        else if (lock_inc) lock_cnt <= lock_cnt + 1'b1;
    end

    // Raster counters, parked at (0,0) outside RUN so every RUN entry starts a fresh frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (run_adv) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end
        end else begin
            h_cnt <= '0;
            v_cnt <= '0;
        end
    end

    assign vis  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_d = (h_cnt >= HS_ON) && (h_cnt < HS_OFF);
    assign vs_d = (v_cnt >= VS_ON) && (v_cnt < VS_OFF);

    // Registered decode: one clock from counter value to outputs, all outputs aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tv_q    <= 1'b0;
            de_q    <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            tv_q <= (next_state == RUN);
            if (run_adv) begin
                de_q    <= vis;
                hsync_q <= hs_d;
                vsync_q <= vs_d;
                fs_q    <= vis && (h_cnt == 12'd0) && (v_cnt == 12'd0);
                ls_q    <= vis && (h_cnt == 12'd0);
                x_q     <= vis ? h_cnt : 12'd0;
                y_q     <= vis ? v_cnt : 12'd0;
            end else begin
                de_q    <= 1'b0;
                hsync_q <= 1'b0;
                vsync_q <= 1'b0;
                fs_q    <= 1'b0;
                ls_q    <= 1'b0;
                x_q     <= '0;
                y_q     <= '0;
            end
        end
    end

`ifdef PIXEL_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0]  bar;
    logic [23:0] rgb_q;

    // Bar index from threshold compares against multiples of the bar width
    always_comb begin
        bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h_cnt >= 12'(i * BAR_W)) bar = 3'(i);
        end
    end

    // Colour bar register, aligned with de and blank outside the visible area
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
        end else if (run_adv && vis) begin
            case (bar)
                3'd0:    rgb_q <= 24'hFFFFFF;
                3'd1:    rgb_q <= 24'hFFFF00;
                3'd2:    rgb_q <= 24'h00FFFF;
                3'd3:    rgb_q <= 24'h00FF00;
                3'd4:    rgb_q <= 24'hFF00FF;
                3'd5:    rgb_q <= 24'hFF0000;
                3'd6:    rgb_q <= 24'h0000FF;
                default: rgb_q <= 24'h000000;
            endcase
        end else begin
            rgb_q <= '0;
        end
    end

    assign vid.rgb = rgb_q;
`else
    assign vid.rgb = 24'h0;
`endif

    assign vid.timing_valid = tv_q;
    assign vid.de           = de_q;
    assign vid.hsync        = hsync_q;
    assign vid.vsync        = vsync_q;
    assign vid.frame_start  = fs_q;
    assign vid.line_start   = ls_q;
    assign vid.pix_x        = x_q;
    assign vid.pix_y        = y_q;
endmodule

// File: tb/tb_pixel_timing_gen.sv
// tb/tb_pixel_timing_gen.sv - self-checking bench for pixel_timing_gen with reduced raster
module tb_pixel_timing_gen;
    localparam int HA = 16, HFP = 3, HS = 2, HBP = 4;
    localparam int VA = 6,  VFP = 1, VS = 2, VBP = 2;
    localparam int LW = 8;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam longint FR = longint'(HT) * longint'(VT);

    typedef struct packed {
        logic        tv, de, hs, vs, fs, ls;
        logic [11:0] x, y;
        logic [23:0] rgb;
    } obs_t;

    typedef struct {
        int   p;
        logic de, hs, vs, fs, ls;
        int   x, y;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pll_locked = 1'b1;
    logic chk_on = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    pixel_timing_if vif ();
    assign vif.pll_locked = pll_locked;

    pixel_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .LOCK_WAIT(LW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vid(vif.master)
    );

    always #5 clk = ~clk;

    // Reference: lk_s is pll_locked two edges late; s counts consecutive edges that saw lk_s=1
    logic   m_a = 1'b0, m_b = 1'b0;
    longint m_s = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a <= 1'b0;
            m_b <= 1'b0;
            m_s <= 0;
        end else begin
            m_a <= pll_locked;
            m_b <= m_a;
            m_s <= m_b ? m_s + 1 : 0;
        end
    end

    function automatic logic [23:0] bar_rgb(longint h);
        longint b;
        b = h / (HA / 8);
        if (b > 7) b = 7;
        case (b)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic obs_t model_out(longint s);
        obs_t   r;
        longint pos, h, v;
        logic   vis;
        r    = '0;
        r.tv = (s >= LW + 1);
        if (s >= LW + 2) begin
            pos  = (s - LW - 2) % FR;
            h    = pos % HT;
            v    = pos / HT;
            vis  = (h < HA) && (v < VA);
            r.de = vis;
            r.hs = (h >= HA + HFP) && (h < HA + HFP + HS);
            r.vs = (v >= VA + VFP) && (v < VA + VFP + VS);
            r.fs = vis && (pos == 0);
            r.ls = vis && (h == 0);
            if (vis) begin
                r.x = 12'(h);
                r.y = 12'(v);
`ifdef PIXEL_TEST_PATTERN_EN
                r.rgb = bar_rgb(h);
`endif
            end
        end
        return r;
    endfunction

    function automatic obs_t observe();
        obs_t r;
        r.tv  = vif.timing_valid;
        r.de  = vif.de;
        r.hs  = vif.hsync;
        r.vs  = vif.vsync;
        r.fs  = vif.frame_start;
        r.ls  = vif.line_start;
        r.x   = vif.pix_x;
        r.y   = vif.pix_y;
        r.rgb = vif.rgb;
        return r;
    endfunction

    // Cycle-by-cycle comparison against the reference, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            obs_t got, want;
            got  = observe();
            want = model_out(m_s);
            n_chk++;
            if (got !== want) begin
                n_err++;
                $display("FAIL model t=%0t got=%h want=%h", $time, got, want);
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic check_range(input string nm, input int got, input int lo, input int hi);
        n_chk++;
        if (got < lo || got > hi) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d..%0d", nm, got, lo, hi);
        end
    endtask

    task automatic wait_tv(output int n, input int budget);
        n = 0;
        while (vif.timing_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic async_reset_pulse(input int hold);
        @(negedge clk);
        #3 rst = 1'b1;
        #1 check("rst_immediate_zero", 64'(observe()), 64'd0);
        repeat (hold) @(negedge clk);
        #3 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    vec_t tbl[17];
    int   n, cur, cnt_de, cnt_fs, cnt_hs, cnt_vs, guard;

    initial begin
        tbl[0]  = '{0,   1, 0, 0, 1, 1, 0,  0};
        tbl[1]  = '{1,   1, 0, 0, 0, 0, 1,  0};
        tbl[2]  = '{15,  1, 0, 0, 0, 0, 15, 0};
        tbl[3]  = '{16,  0, 0, 0, 0, 0, 0,  0};
        tbl[4]  = '{19,  0, 1, 0, 0, 0, 0,  0};
        tbl[5]  = '{20,  0, 1, 0, 0, 0, 0,  0};
        tbl[6]  = '{21,  0, 0, 0, 0, 0, 0,  0};
        tbl[7]  = '{25,  1, 0, 0, 0, 1, 0,  1};
        tbl[8]  = '{140, 1, 0, 0, 0, 0, 15, 5};
        tbl[9]  = '{150, 0, 0, 0, 0, 0, 0,  0};
        tbl[10] = '{168, 0, 0, 0, 0, 0, 0,  0};
        tbl[11] = '{175, 0, 0, 1, 0, 0, 0,  0};
        tbl[12] = '{194, 0, 1, 1, 0, 0, 0,  0};
        tbl[13] = '{224, 0, 0, 1, 0, 0, 0,  0};
        tbl[14] = '{225, 0, 0, 0, 0, 0, 0,  0};
        tbl[15] = '{274, 0, 0, 0, 0, 0, 0,  0};
        tbl[16] = '{275, 1, 0, 0, 1, 1, 0,  0};

        // Reset held with lock present: everything blank
        repeat (4) @(negedge clk);
        chk_on = 1'b1;
        check("reset_outputs", 64'(observe()), 64'd0);

        // Release reset, lock qualification latency
        #3 rst = 1'b0;
        wait_tv(n, 200);
        check_range("lock_latency", n, LW + 1, LW + 3);

        // Raster decode at the boundary positions of the first frames
        cur = -1;
        for (int i = 0; i < 17; i++) begin
            repeat (tbl[i].p - cur) @(negedge clk);
            cur = tbl[i].p;
            check($sformatf("table[%0d] p=%0d", i, tbl[i].p),
                  64'({vif.timing_valid, vif.de, vif.hsync, vif.vsync, vif.frame_start,
                       vif.line_start, vif.pix_x, vif.pix_y}),
                  64'({1'b1, tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].fs, tbl[i].ls,
                       12'(tbl[i].x), 12'(tbl[i].y)}));
        end

        // One whole frame of activity counts
        cnt_de = 0; cnt_fs = 0; cnt_hs = 0; cnt_vs = 0;
        for (int i = 0; i < HT * VT; i++) begin
            cnt_de += int'(vif.de);
            cnt_fs += int'(vif.frame_start);
            cnt_hs += int'(vif.hsync);
            cnt_vs += int'(vif.vsync);
            @(negedge clk);
        end
        check("frame_de_count", 64'(cnt_de), 64'(HA * VA));
        check("frame_fs_count", 64'(cnt_fs), 64'd1);
        check("frame_hs_count", 64'(cnt_hs), 64'(HS * VT));
        check("frame_vs_count", 64'(cnt_vs), 64'(VS * HT));

        // Lock lost mid-line: blank within three clocks, relock restarts at (0,0)
        guard = 0;
        while (!(vif.de === 1'b1 && vif.pix_x == 12'd5) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check_range("find_mid_line", guard, 0, 999);
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        check("lock_loss_blank", 64'(observe()), 64'd0);
        repeat (4) @(negedge clk);
        pll_locked = 1'b1;
        wait_tv(n, 200);
        check_range("relock_latency", n, LW + 1, LW + 3);
        @(negedge clk);
        check("relock_frame_start", 64'({vif.frame_start, vif.de, vif.pix_x, vif.pix_y}),
              64'({1'b1, 1'b1, 12'd0, 12'd0}));

        // Asynchronous reset mid-frame, then normal restart
        repeat (50) @(negedge clk);
        async_reset_pulse(2);
        wait_tv(n, 200);
        check_range("post_rst_latency", n, LW + 1, LW + 3);
        @(negedge clk);
        check("post_rst_frame_start", 64'({vif.frame_start, vif.de, vif.pix_x, vif.pix_y}),
              64'({1'b1, 1'b1, 12'd0, 12'd0}));

        // One-clock lock glitch in SETTLE restarts the full qualification
        async_reset_pulse(2);
        repeat (5) @(negedge clk);
        check("settle_not_run", 64'(vif.timing_valid), 64'd0);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        wait_tv(n, 200);
        check_range("glitch_restart_latency", n, LW + 2, LW + 4);

        // Randomised lock dropouts and occasional resets against the reference
        for (int k = 0; k < 25; k++) begin
            pll_locked = 1'b1;
            repeat ($urandom_range(1, 400)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) async_reset_pulse($urandom_range(0, 3));
            pll_locked = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        pll_locked = 1'b1;
        repeat (LW + 40) @(negedge clk);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
